pe_mx: RTL
==========

# pe_mx

Multi-format systolic processing element, next generation of the array's FP8 MAC cell. Accepts FP8 operands in E4M3 or E5M2, selected per tile. Accumulates aligned products into a parametrised signed fixed-point accumulator over a programmable reduction length K. Emits a registered BF16 result with a valid strobe when each tile completes, while forwarding operands to its neighbours in the array.

## Interface
- `ACC_W`, 24: accumulator width in bits, two's complement.
- `FRAC_W`, 8: fractional bits of the accumulator; the accumulator LSB weighs 2^-FRAC_W.
- `CNT_W`, 8: width of the K counter and of `k_len`.
- Clock is `clk` and reset is `rst`: one clock, reset synchronous and active-high.
- `clk` input 1: clock, rising edge.
- `rst` input 1: synchronous active-high reset.
- `clear` input 1: synchronous tile abort and flush.
- `fmt` input 1: operand format, 0 = E4M3 (bias 7, 3 mantissa bits), 1 = E5M2 (bias 15, 2 mantissa bits).
- `k_len` input CNT_W: products per tile; 0 is treated as 1.
- `in_valid` input 1: `a_in`/`b_in` carry a beat.
- `a_in`, `b_in` input 8: FP8 operands.
- `a_out`, `b_out` output 8: registered operand pass-through.
- `valid_out` output 1: registered `in_valid` pass-through.
- `c_out` output 16: BF16 tile result.
- `c_valid` output 1: one-cycle strobe qualifying `c_out`.
- `ovf` output 1: sticky flag, accumulator overflow seen in the current tile.
- `exc` output 1: sticky flag, NaN/Inf operand seen in the current tile.

## Operation
- **Pass-through:** `a_out`/`b_out`/`valid_out` take `a_in`/`b_in`/`in_valid` every cycle, independent of `clear`. They are zeroed only by `rst`.
- **Decode:**
  - Exponent 0 → denormal: effective exponent 1, hidden bit 0. Otherwise hidden bit 1.
  - E4M3 exponent 1111 with mantissa 111 → NaN.
  - E5M2 exponent 11111 → Inf/NaN.
  - A special operand contributes 0 and sets `exc`.
- **Stage 1 (registered):**
  - sign = sa^sb.
  - mag = mant_a*mant_b.
  - shift = ea+eb − (2·bias + 2·mbits) + FRAC_W, signed.
  - Positive shift: shift mag left. Negative shift: shift right, truncating.
  - The aligned magnitude is computed at ACC_W+8 bits. Magnitude ≥ 2^(ACC_W−1) marks the beat as overflowing.
  - `fmt` is latched with the beat.
- **Stage 2 (accumulate):** acc ← acc ± aligned.
  - Signed overflow of the ACC_W sum, or an overflowing beat, sets `ovf`.
- **FSM:**
  - IDLE: count = 0. A valid beat latches `k_len` into `k_lat` → ACC.
  - ACC: each stage-2 beat increments count. The beat where count reaches `k_lat` → EMIT.
  - EMIT (one cycle): `c_out` ← BF16(acc_final) and `c_valid` = 1. acc, count, `ovf` and `exc` restart. If a beat is in stage 2 that cycle, it seeds the new tile: acc = that product, count = 1, state ACC. Otherwise state → IDLE.
- **BF16 conversion:**
  - acc = 0 → 0x0000.
  - Otherwise sign = acc MSB and |acc| is found by leading-zero detection; p = MSB position.
  - exponent = 127 + p − FRAC_W.
  - Mantissa = the 7 bits below the MSB, truncated toward zero. There is no rounding.
- **Precedence:** `rst` > `clear` > beat.
  - `clear` empties stage 1, zeroes acc, count, `ovf` and `exc`, returns to IDLE, and suppresses `c_valid` that cycle.
- **Reset values:** all outputs 0. FSM state IDLE.
- **Mid-tile `fmt` change:** `fmt` is sampled per beat; the bench keeps it constant within a tile.
- **Counter limit:** count never wraps, because `k_lat` ≤ 2^CNT_W−1.

## Timing
- Pass-through latency is 1 cycle.
- A beat presented at cycle t is in stage 1 at t+1 and in the accumulator at t+2. For the last beat of a tile, `c_out`/`c_valid` are asserted at t+3.
- Back-to-back beats are accepted every cycle with no bubbles, including across tile boundaries.
- `c_out` holds its value until the next EMIT. `c_valid` is high for exactly one cycle.
- `ovf`/`exc` are visible the cycle after the offending beat reaches stage 2. They clear at EMIT, `clear` or `rst`.

## Configuration
- `PE_MX_SAT_EN` defined: on overflow, the accumulator clamps to +(2^(ACC_W−1)−1) or −2^(ACC_W−1) according to the sign of the true result. It holds the clamp until the tile ends and later beats have no effect. `ovf` is set.
- `PE_MX_SAT_EN` not defined: the accumulator wraps modulo 2^ACC_W. `ovf` is still set.

## Test plan
- **Single 1×1 tile:** `fmt`=0, `k_len`=1, one beat 0x38×0x38 → `c_valid` 3 cycles later, `c_out`=0x3F80. `a_out`/`b_out` = 0x38 one cycle after the beat.
- **K = 4:** `k_len`=4, four back-to-back 0x38×0x38 beats → exactly one strobe, `c_out`=0x4080. A 5th beat in the following cycle starts a new tile (count 1).
- **Signed sum:** `k_len`=3, beats 0x38×0x38, 0xB8×0x38, 0x38×0x38 → `c_out`=0x3F80. Then `fmt`=1 with 0x3C×0x3C, `k_len`=1 → 0x3F80.
- **Overflow:** 0x7E×0x7E (448²) with `k_len`=1.
  - With `PE_MX_SAT_EN`: `ovf`=1, `c_out`=0x46FF.
  - Without it: `ovf`=1, `c_out` equals the wrapped value from the reference model.
- **Exceptions:** beat 0x7F×0x38 (`fmt`=0) → `exc`=1, contribution 0. With `k_len`=2 and a following 0x38×0x38, `c_out`=0x3F80.
- **Abort and reset:** `clear` asserted mid-tile after 2 of 4 beats → no strobe, acc 0, state IDLE. A new 1-beat tile yields 0x3F80. Asserting `rst` on the cycle a strobe would fire → `c_valid`=0 and all outputs 0 on the next cycle.

Source files
------------

// File: rtl/pe_mx.sv
// Multi-format FP8 (E4M3/E5M2) systolic MAC cell: fixed-point accumulation over K beats, BF16 tile result.
// Optional build macro PE_MX_SAT_EN: saturating accumulator instead of modulo wrap.
module pe_mx #(
    parameter int ACC_W  = 24,
    parameter int FRAC_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             fmt,
    input  logic [CNT_W-1:0] k_len,
    input  logic             in_valid,
    input  logic [7:0]       a_in,
    input  logic [7:0]       b_in,
    output logic [7:0]       a_out,
    output logic [7:0]       b_out,
    output logic             valid_out,
    output logic [15:0]      c_out,
    output logic             c_valid,
    output logic             ovf,
    output logic             exc
);

    localparam int AL_W   = ACC_W + 8;
    localparam int WIDE_W = ACC_W + 24;
    localparam int SUM_W  = ACC_W + 10;

`ifdef PE_MX_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACC, EMIT} state_t;

    // Returns {special, eff_exp[4:0], mant[3:0]}; mant holds the hidden bit above the stored bits.
    function automatic logic [9:0] decode(input logic [7:0] x, input logic f);
        logic [4:0] e;
        logic [3:0] m;
        logic       sp;
        if (!f) begin
            e  = {1'b0, x[6:3]};
            sp = (x[6:3] == 4'hF) && (x[2:0] == 3'h7);
            m  = {(e != 5'd0), x[2:0]};
        end else begin
            e  = x[6:2];
            sp = &x[6:2];
            m  = {1'b0, (e != 5'd0), x[1:0]};
        end
        if (e == 5'd0) e = 5'd1;
        decode = {sp, e, m};
    endfunction

    function automatic logic out_of_range(input logic [SUM_W-1:0] s);
        out_of_range = (s[SUM_W-1:ACC_W-1] != {(SUM_W-ACC_W+1){s[ACC_W-1]}});
    endfunction

    function automatic logic [ACC_W-1:0] wrap_or_sat(input logic [SUM_W-1:0] s, input logic o,
                                                     input logic neg);
        if (SAT_EN && o)
            wrap_or_sat = neg ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            wrap_or_sat = s[ACC_W-1:0];
    endfunction

    function automatic logic [15:0] to_bf16(input logic [ACC_W-1:0] v);
        logic [ACC_W-1:0] mag;
        logic [ACC_W-1:0] norm;
        logic [7:0]       p;
        mag = v[ACC_W-1] ? (~v + 1'b1) : v;
        p   = 8'd0;
        for (int i = 0; i < ACC_W; i++)
            if (mag[i]) p = 8'(i);
        norm = mag << (8'(ACC_W-1) - p);
        if (v == '0)
            to_bf16 = 16'h0000;
        else
            to_bf16 = {v[ACC_W-1], 8'(127 - FRAC_W) + p, norm[ACC_W-2 -: 7]};
    endfunction

    logic [7:0] op [2];
    logic [9:0] dec [2];
    assign op[0] = a_in;
    assign op[1] = b_in;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dec
            assign dec[gi] = decode(op[gi], fmt);
        end
    endgenerate

    // Stage 1: product, alignment shift and per-beat overflow detection.
    logic              sp;
    logic [7:0]        mag, shift_v, sh_amt;
    logic [WIDE_W-1:0] wide;
    logic              big;
    always_comb begin
        sp      = dec[0][9] | dec[1][9];
        mag     = sp ? 8'd0 : ({4'd0, dec[0][3:0]} * {4'd0, dec[1][3:0]});
        shift_v = {3'd0, dec[0][8:4]} + {3'd0, dec[1][8:4]} + 8'(FRAC_W)
                  - (fmt ? 8'd34 : 8'd20);
        sh_amt  = shift_v[7] ? (8'd0 - shift_v) : shift_v;
        wide    = {{(WIDE_W-8){1'b0}}, mag};
        wide    = shift_v[7] ? (wide >> sh_amt) : (wide << sh_amt);
        big     = |wide[WIDE_W-1:ACC_W-1];
    end

    logic             s1_valid_reg, s1_sign_reg, s1_big_reg, s1_exc_reg;
    logic [AL_W-1:0]  s1_aligned_reg;
    logic [CNT_W-1:0] s1_k_reg;
    logic [ACC_W-1:0] acc_reg;
    logic [CNT_W-1:0] count_reg, k_lat_reg;
    state_t           state_reg;

    // Stage 2: the same beat either adds into the running tile or seeds a fresh one at EMIT.
    logic [SUM_W-1:0] addend, sum_acc;
    logic             acc_ovf, seed_ovf;
    logic [ACC_W-1:0] acc_next, seed_next;
    always_comb begin
        addend = {2'b00, s1_aligned_reg};
        if (s1_sign_reg) addend = '0 - addend;
        sum_acc   = {{(SUM_W-ACC_W){acc_reg[ACC_W-1]}}, acc_reg} + addend;
        acc_ovf   = s1_big_reg | out_of_range(sum_acc);
        seed_ovf  = s1_big_reg | out_of_range(addend);
        acc_next  = wrap_or_sat(sum_acc, acc_ovf, s1_big_reg ? s1_sign_reg : sum_acc[SUM_W-1]);
        seed_next = wrap_or_sat(addend, seed_ovf, s1_sign_reg);
        if (SAT_EN && ovf) acc_next = acc_reg;
    end

    logic [CNT_W-1:0] k_eff, count_inc;
    assign k_eff     = (k_len == '0) ? CNT_W'(1) : k_len;
    assign count_inc = count_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_out          <= '0;
            b_out          <= '0;
            valid_out      <= 1'b0;
            c_out          <= '0;
            c_valid        <= 1'b0;
            ovf            <= 1'b0;
            exc            <= 1'b0;
            s1_valid_reg   <= 1'b0;
            s1_sign_reg    <= 1'b0;
            s1_big_reg     <= 1'b0;
            s1_exc_reg     <= 1'b0;
            s1_aligned_reg <= '0;
            s1_k_reg       <= '0;
            acc_reg        <= '0;
            count_reg      <= '0;
            k_lat_reg      <= '0;
            state_reg      <= IDLE;
        end else begin
            a_out     <= a_in;
            b_out     <= b_in;
            valid_out <= in_valid;
            c_valid   <= 1'b0;
            if (clear) begin
                s1_valid_reg <= 1'b0;
                acc_reg      <= '0;
                count_reg    <= '0;
                ovf          <= 1'b0;
                exc          <= 1'b0;
                state_reg    <= IDLE;
            end else begin
                s1_valid_reg   <= in_valid;
                s1_sign_reg    <= a_in[7] ^ b_in[7];
                s1_big_reg     <= big;
                s1_exc_reg     <= sp;
                s1_aligned_reg <= wide[AL_W-1:0];
                s1_k_reg       <= k_eff;
                case (state_reg)
                    IDLE: begin
                        count_reg <= '0;
                        if (in_valid) begin
                            k_lat_reg <= k_eff;
                            state_reg <= ACC;
                        end
                    end
                    ACC: begin
                        if (s1_valid_reg) begin
                            acc_reg   <= acc_next;
                            ovf       <= ovf | acc_ovf;
                            exc       <= exc | s1_exc_reg;
                            count_reg <= count_inc;
                            if (count_inc == k_lat_reg) state_reg <= EMIT;
                        end
                    end
                    EMIT: begin
                        c_out   <= to_bf16(acc_reg);
                        c_valid <= 1'b1;
                        if (s1_valid_reg) begin
                            acc_reg   <= seed_next;
                            ovf       <= seed_ovf;
                            exc       <= s1_exc_reg;
                            count_reg <= CNT_W'(1);
                            k_lat_reg <= s1_k_reg;
                            state_reg <= (s1_k_reg == CNT_W'(1)) ? EMIT : ACC;
                        end else begin
                            acc_reg   <= '0;
                            ovf       <= 1'b0;
                            exc       <= 1'b0;
                            count_reg <= '0;
                            k_lat_reg <= k_eff;
                            state_reg <= in_valid ? ACC : IDLE;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule
